// File: rtl/pio_host_seq_if.sv
// Stream, config-ROM and pio-facing signal bundle for pio_host_seq.
// slave = sequencer side, master = SoC / ROM / pio side.
interface pio_host_seq_if #(
  parameter int CFG_AW = 6
);
  logic              start;
  logic [CFG_AW-1:0] cfg_len;
  logic [CFG_AW-1:0] cfg_addr;
  logic [42:0]       cfg_data;
  logic              busy;
  logic              running;
  logic              tx_valid;
  logic              tx_ready;
  logic [1:0]        tx_sm;
  logic [31:0]       tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [1:0]        rx_sm;
  logic [31:0]       rx_data;
  logic [3:0]        action;
  logic [4:0]        index;
  logic [1:0]        mindex;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic [3:0]        tx_full;
  logic [3:0]        rx_empty;

  modport slave (
    input  start, cfg_len, cfg_data,
    input  tx_valid, tx_sm, tx_data,
    input  rx_ready, dout, tx_full, rx_empty,
    output cfg_addr, busy, running, tx_ready,
    output rx_valid, rx_sm, rx_data,
    output action, index, mindex, din
  );

  modport master (
    output start, cfg_len, cfg_data,
    output tx_valid, tx_sm, tx_data,
    output rx_ready, dout, tx_full, rx_empty,
    input  cfg_addr, busy, running, tx_ready,
    input  rx_valid, rx_sm, rx_data,
    input  action, index, mindex, din
  );
endinterface

// File: rtl/pio_host_seq.sv
// pio host sequencer: replays a config ROM into pio, then arbitrates
// TX pushes and round-robin RX pulls, one pio action per cycle.
module pio_host_seq #(
  parameter int NUM_SM = 4,
  parameter int CFG_AW = 6,
  parameter int RX_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  pio_host_seq_if.slave bus
);

  localparam logic [3:0] A_NONE = 4'd0;
  localparam logic [3:0] A_PULL = 4'd3;
  localparam logic [3:0] A_PUSH = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_load_go;

  logic [CFG_AW-1:0] r_addr;
  logic [CFG_AW-1:0] r_len;
  logic              r_fetch;
  logic              r_dv;
  logic              r_last;
  logic              r_busy;

  logic [3:0]  r_action;
  logic [4:0]  r_index;
  logic [1:0]  r_mindex;
  logic [31:0] r_din;

  logic        r_rx_valid;
  logic [1:0]  r_rx_sm;
  logic [31:0] r_rx_data;
  logic [RX_LAT:0] r_pipe;
  logic [1:0]  r_pull_sm;
  logic [1:0]  r_rr;
  logic        r_tx_pri;

  logic       w_run;
  logic       w_tx_inrange;
  logic       w_tx_block;
  logic       w_tx_elig;
  logic       w_tx_drop;
  logic       w_rx_any;
  logic [1:0] w_rx_sm;
  logic [1:0] w_rr_nxt;
  logic       w_rx_elig;
  logic       w_grant_tx;
  logic       w_grant_rx;
  logic       w_cfg_issue;
  logic [3:0] w_cfg_act;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load_go = 1'b0;
    unique case (r_state)
      S_IDLE, S_RUN: begin
        if (bus.start) begin
          if (bus.cfg_len == '0) begin
            w_next = S_RUN;
          end else begin
            w_next    = S_LOAD;
            w_load_go = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (r_last) w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_run = (r_state == S_RUN);

  // a PUSH currently on the bus has not yet reached pio's full flag
  assign w_tx_inrange = (int'(bus.tx_sm) < NUM_SM);
  assign w_tx_block   = (r_action == A_PUSH) &&
                        (r_mindex == bus.tx_sm);
  assign w_tx_elig    = w_run && bus.tx_valid &&
                        w_tx_inrange &&
                        !bus.tx_full[bus.tx_sm] &&
                        !w_tx_block;
  assign w_tx_drop    = w_run && bus.tx_valid &&
                        !w_tx_inrange;

  always_comb begin
    logic [2:0] sum;
    sum      = '0;
    w_rx_any = 1'b0;
    w_rx_sm  = r_rr;
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      sum = {1'b0, r_rr} + 3'(i);
      if (sum >= 3'(NUM_SM)) sum = sum - 3'(NUM_SM);
      if (!bus.rx_empty[sum[1:0]]) begin
        w_rx_any = 1'b1;
        w_rx_sm  = sum[1:0];
      end
    end
  end

  always_comb begin
    logic [2:0] inc;
    inc      = {1'b0, w_rx_sm} + 3'd1;
    w_rr_nxt = inc[1:0];
    if (inc >= 3'(NUM_SM)) w_rr_nxt = 2'd0;
  end

  assign w_rx_elig  = w_run && !r_rx_valid &&
                      !(|r_pipe) && w_rx_any;
  assign w_grant_tx = w_tx_elig &&
                      (!w_rx_elig || r_tx_pri);
  assign w_grant_rx = w_rx_elig && !w_grant_tx;

  assign w_cfg_issue = (r_state == S_LOAD) && r_dv;

  always_comb begin
    w_cfg_act = bus.cfg_data[42:39];
    if (w_cfg_act == A_PUSH || w_cfg_act == A_PULL)
      w_cfg_act = A_NONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_fetch    <= 1'b0;
      r_dv       <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_action   <= A_NONE;
      r_index    <= '0;
      r_mindex   <= '0;
      r_din      <= '0;
      r_rx_valid <= 1'b0;
      r_rx_sm    <= '0;
      r_rx_data  <= '0;
      r_pipe     <= '0;
      r_pull_sm  <= '0;
      r_rr       <= '0;
      r_tx_pri   <= 1'b1;
    end else begin
      r_action <= A_NONE;
      r_busy   <= w_cfg_issue;
      r_pipe   <= {r_pipe[RX_LAT-1:0], w_grant_rx};

      if (r_pipe[RX_LAT]) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= bus.dout;
        r_rx_sm    <= r_pull_sm;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      // ROM address leads the issued entry by its read latency
      if (w_load_go) begin
        r_addr  <= '0;
        r_len   <= bus.cfg_len;
        r_fetch <= 1'b1;
        r_dv    <= 1'b0;
        r_last  <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_dv   <= r_fetch;
        r_last <= r_dv && !r_fetch;
        if (r_fetch) begin
          if (r_addr == r_len - 1'b1) r_fetch <= 1'b0;
          else                        r_addr  <= r_addr + 1'b1;
        end
      end else begin
        r_dv   <= 1'b0;
        r_last <= 1'b0;
      end

      unique case (1'b1)
        w_cfg_issue: begin
          r_action <= w_cfg_act;
          r_mindex <= bus.cfg_data[38:37];
          r_index  <= bus.cfg_data[36:32];
          r_din    <= bus.cfg_data[31:0];
        end
        w_grant_tx: begin
          r_action <= A_PUSH;
          r_mindex <= bus.tx_sm;
          r_index  <= '0;
          r_din    <= bus.tx_data;
        end
        w_grant_rx: begin
          r_action  <= A_PULL;
          r_mindex  <= w_rx_sm;
          r_index   <= '0;
          r_din     <= '0;
          r_pull_sm <= w_rx_sm;
          r_rr      <= w_rr_nxt;
        end
        default: ;
      endcase

      if (!w_run || bus.start) r_tx_pri <= 1'b1;
      else if (w_grant_tx)     r_tx_pri <= 1'b0;
      else if (w_grant_rx)     r_tx_pri <= 1'b1;
    end
  end

  assign bus.cfg_addr = r_addr;
  assign bus.busy     = r_busy;
  assign bus.running  = w_run;
  assign bus.tx_ready = w_grant_tx || w_tx_drop;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_sm    = r_rx_sm;
  assign bus.rx_data  = r_rx_data;
  assign bus.action   = r_action;
  assign bus.index    = r_index;
  assign bus.mindex   = r_mindex;
  assign bus.din      = r_din;

endmodule

// File: tb/tb_pio_host_seq.sv
// Directed bench for pio_host_seq with a sync ROM model and a
// registered pio dout model (RX_LAT = 1).
module tb_pio_host_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pio_host_seq_if #(.CFG_AW(6)) b();

  pio_host_seq #(
    .NUM_SM(4),
    .CFG_AW(6),
    .RX_LAT(1)
  ) dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (b)
  );

  typedef struct {
    logic [42:0] w;
    logic [3:0]  exp_act;
  } vec_t;

  vec_t tv[10];
  logic [42:0] rom [64];
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) begin
    b.cfg_data <= rom[b.cfg_addr];
    if (b.action == 4'd3)
      b.dout <= 32'hA5 | (32'(b.mindex) << 8);
  end

  function automatic logic [42:0] mk(
    input logic [3:0]  a,
    input logic [1:0]  m,
    input logic [4:0]  i,
    input logic [31:0] d
  );
    return {a, m, i, d};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_action"},   32'(b.action),   0);
    chk({tag, "_index"},    32'(b.index),    0);
    chk({tag, "_mindex"},   32'(b.mindex),   0);
    chk({tag, "_din"},      b.din,           0);
    chk({tag, "_cfg_addr"}, 32'(b.cfg_addr), 0);
    chk({tag, "_busy"},     32'(b.busy),     0);
    chk({tag, "_running"},  32'(b.running),  0);
    chk({tag, "_tx_ready"}, 32'(b.tx_ready), 0);
    chk({tag, "_rx_valid"}, 32'(b.rx_valid), 0);
    chk({tag, "_rx_sm"},    32'(b.rx_sm),    0);
    chk({tag, "_rx_data"},  b.rx_data,       0);
  endtask

  task automatic drain_rx();
    b.rx_empty = 4'hF;
    b.rx_ready = 1'b1;
    repeat (6) @(negedge clk);
    b.rx_ready = 1'b0;
  endtask

  initial begin
    tv[0] = '{mk(4'd1,  2'd0, 5'd0, 32'h0000E081), 4'd1};
    tv[1] = '{mk(4'd1,  2'd1, 5'd1, 32'h00006001), 4'd1};
    tv[2] = '{mk(4'd2,  2'd0, 5'd0, 32'h00001000), 4'd2};
    tv[3] = '{mk(4'd7,  2'd0, 5'd0, 32'h00000C80), 4'd7};
    tv[4] = '{mk(4'd5,  2'd2, 5'd0, 32'h20100001), 4'd5};
    tv[5] = '{mk(4'd10, 2'd0, 5'd0, 32'h10830000), 4'd10};
    tv[6] = '{mk(4'd6,  2'd3, 5'd0, 32'h00000001), 4'd6};
    tv[7] = '{mk(4'd4,  2'd1, 5'd0, 32'hDEADBEEF), 4'd0};
    tv[8] = '{mk(4'd1,  2'd2, 5'd3, 32'h0000A0A0), 4'd1};
    tv[9] = '{mk(4'd3,  2'd3, 5'd0, 32'h00000000), 4'd0};
    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int k = 0; k < 7; k++) rom[k] = tv[k].w;

    rst_n      = 1'b0;
    b.start    = 1'b0;
    b.cfg_len  = '0;
    b.tx_valid = 1'b0;
    b.tx_sm    = 2'd0;
    b.tx_data  = '0;
    b.rx_ready = 1'b0;
    b.tx_full  = 4'h0;
    b.rx_empty = 4'hF;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // config replay of 7 entries
    @(negedge clk);
    b.start   = 1'b1;
    b.cfg_len = 6'd7;
    @(negedge clk);
    b.start = 1'b0;
    chk("ld_addr0", 32'(b.cfg_addr), 0);
    chk("ld_lat0",  32'(b.action),   0);
    @(negedge clk);
    chk("ld_addr1", 32'(b.cfg_addr), 1);
    chk("ld_lat1",  32'(b.action),   0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("cfg_act", 32'(b.action),  32'(tv[k].exp_act));
      chk("cfg_mi",  32'(b.mindex),  32'(tv[k].w[38:37]));
      chk("cfg_idx", 32'(b.index),   32'(tv[k].w[36:32]));
      chk("cfg_din", b.din,          tv[k].w[31:0]);
      chk("cfg_busy", 32'(b.busy),   1);
      chk("cfg_run0", 32'(b.running), 0);
    end
    @(negedge clk);
    chk("ld_done_act",  32'(b.action),  0);
    chk("ld_done_busy", 32'(b.busy),    0);
    chk("ld_done_run",  32'(b.running), 1);

    // TX push and full back-pressure
    b.tx_valid = 1'b1;
    b.tx_sm    = 2'd0;
    b.tx_data  = 32'h40000000;
    #1 chk("tx0_ready", 32'(b.tx_ready), 1);
    @(negedge clk);
    chk("tx0_act", 32'(b.action), 4);
    chk("tx0_mi",  32'(b.mindex), 0);
    chk("tx0_din", b.din, 32'h40000000);
    b.tx_valid = 1'b0;
    @(negedge clk);
    chk("tx0_once", 32'(b.action), 0);
    b.tx_full  = 4'b0010;
    b.tx_sm    = 2'd1;
    b.tx_data  = 32'h12345678;
    b.tx_valid = 1'b1;
    #1 chk("tx1_full_rdy", 32'(b.tx_ready), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tx1_full_act", 32'(b.action),   0);
      chk("tx1_full_rdy", 32'(b.tx_ready), 0);
    end
    b.tx_full = 4'b0000;
    #1 chk("tx1_rdy", 32'(b.tx_ready), 1);
    @(negedge clk);
    chk("tx1_act", 32'(b.action), 4);
    chk("tx1_mi",  32'(b.mindex), 1);
    chk("tx1_din", b.din, 32'h12345678);
    b.tx_valid = 1'b0;

    // RX round robin over sm0/sm2
    b.rx_empty = 4'b1010;
    @(negedge clk);
    chk("rx0_act", 32'(b.action), 3);
    chk("rx0_mi",  32'(b.mindex), 0);
    @(negedge clk);
    chk("rx0_gap", 32'(b.action),   0);
    chk("rx0_nv",  32'(b.rx_valid), 0);
    @(negedge clk);
    chk("rx0_v",    32'(b.rx_valid), 1);
    chk("rx0_data", b.rx_data, 32'h000000A5);
    chk("rx0_sm",   32'(b.rx_sm), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rx_hold_act", 32'(b.action),   0);
      chk("rx_hold_v",   32'(b.rx_valid), 1);
    end
    b.rx_ready = 1'b1;
    @(negedge clk);
    chk("rx0_clr", 32'(b.rx_valid), 0);
    chk("rx0_clr_act", 32'(b.action), 0);
    b.rx_ready = 1'b0;
    @(negedge clk);
    chk("rx1_act", 32'(b.action), 3);
    chk("rx1_mi",  32'(b.mindex), 2);
    @(negedge clk);
    @(negedge clk);
    chk("rx1_v",    32'(b.rx_valid), 1);
    chk("rx1_data", b.rx_data, 32'h000002A5);
    chk("rx1_sm",   32'(b.rx_sm), 2);
    b.rx_ready = 1'b1;
    @(negedge clk);
    b.rx_ready = 1'b0;
    @(negedge clk);
    chk("rx2_act", 32'(b.action), 3);
    chk("rx2_mi",  32'(b.mindex), 0);
    drain_rx();

    // re-config from RUN; PUSH/PULL entries suppressed
    rom[0] = tv[7].w;
    rom[1] = tv[8].w;
    rom[2] = tv[9].w;
    b.start   = 1'b1;
    b.cfg_len = 6'd3;
    @(negedge clk);
    b.start    = 1'b0;
    b.tx_valid = 1'b1;
    b.tx_sm    = 2'd0;
    b.tx_data  = 32'h00000011;
    b.rx_empty = 4'b0000;
    b.rx_ready = 1'b1;
    #1 chk("ld_txrdy", 32'(b.tx_ready), 0);
    @(negedge clk);
    chk("ld_txrdy", 32'(b.tx_ready), 0);
    for (int k = 7; k < 10; k++) begin
      @(negedge clk);
      chk("rc_act",  32'(b.action), 32'(tv[k].exp_act));
      chk("rc_busy", 32'(b.busy), 1);
      chk("ld_txrdy", 32'(b.tx_ready), 0);
    end

    // contention: PUSH first, then alternate
    @(negedge clk);
    chk("ct_run", 32'(b.running), 1);
    chk("ct_idle_act", 32'(b.action), 0);
    #1 chk("ct_rdy0", 32'(b.tx_ready), 1);
    @(negedge clk);
    chk("ct_act0", 32'(b.action), 4);
    chk("ct_mi0",  32'(b.mindex), 0);
    b.tx_sm   = 2'd1;
    b.tx_data = 32'h00000022;
    #1 chk("ct_rdy1", 32'(b.tx_ready), 0);
    @(negedge clk);
    chk("ct_act1", 32'(b.action), 3);
    #1 chk("ct_rdy2", 32'(b.tx_ready), 1);
    @(negedge clk);
    chk("ct_act2", 32'(b.action), 4);
    chk("ct_mi2",  32'(b.mindex), 1);
    chk("ct_din2", b.din, 32'h00000022);
    b.tx_valid = 1'b0;
    drain_rx();

    // reset in the middle of an RX read
    b.rx_empty = 4'b1110;
    @(negedge clk);
    chk("rr_pull", 32'(b.action), 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst_rx");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_rx_nv",  32'(b.rx_valid), 0);
      chk("rst_rx_act", 32'(b.action),   0);
    end

    // reset in the middle of LOAD
    for (int k = 0; k < 3; k++) rom[k] = tv[k].w;
    b.rx_empty = 4'hF;
    b.start    = 1'b1;
    b.cfg_len  = 6'd7;
    @(negedge clk);
    b.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rl_mid", 32'(b.action), 32'(tv[1].exp_act));
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst_ld");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ld_act",  32'(b.action),  0);
      chk("rst_ld_busy", 32'(b.busy),    0);
      chk("rst_ld_run",  32'(b.running), 0);
    end

    // cfg_len = 0 goes straight to RUN
    b.start   = 1'b1;
    b.cfg_len = 6'd0;
    @(negedge clk);
    b.start = 1'b0;
    chk("z_run",  32'(b.running), 1);
    chk("z_busy", 32'(b.busy),    0);
    chk("z_act",  32'(b.action),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
